tone_i2s_out: RTL and testbench

//  Downstream of the volume controller. Turns note enables plus the volume_max/volume_min

---
 rtl/audio_pkg.sv | 29 ++
 rtl/i2s_serializer.sv | 63 ++++++
 rtl/tone_i2s_out.sv | 83 ++++++++
 tb/tb_tone_i2s_out.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared constants and note encoding for the tone-to-I2S audio path.
// Frame geometry is fixed: 1024 clk per stereo frame, 16-bit samples in 32-slot channels.
package audio_pkg;

   localparam int FRAME_W     = 10;
   localparam int SLOT_BITS   = 16;
   localparam int TONE_W_DEF  = 18;
   localparam int DO_HALF_DEF = 190839;
   localparam int RE_HALF_DEF = 170068;
   localparam int MI_HALF_DEF = 151515;

   typedef enum logic [1:0] {
      NOTE_NONE = 2'd0,
      NOTE_DO   = 2'd1,
      NOTE_RE   = 2'd2,
      NOTE_MI   = 2'd3
   } note_e;

   // Priority is Do > Re > Mi when several enables are high together.
   function automatic note_e noteSelect(input logic doEn, input logic reEn, input logic miEn);
      note_e sel;
      if (doEn)      sel = NOTE_DO;
      else if (reEn) sel = NOTE_RE;
      else if (miEn) sel = NOTE_MI;
      else           sel = NOTE_NONE;
      return sel;
   endfunction

endpackage

// File: rtl/i2s_serializer.sv
// Free-running I2S frame generator: derives MCLK/SCK/LRCK from one counter and
// shifts a held 16-bit sample MSB-first into both channels of each frame.
module i2s_serializer
   import audio_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [SLOT_BITS-1:0] sample_i,
   output logic                 mclk_o,
   output logic                 sck_o,
   output logic                 lrck_o,
   output logic                 sdin_o,
   output logic                 sampleTick_o
);

   logic [FRAME_W-1:0]     frameCnt_q;
   logic [SLOT_BITS-1:0]   hold_q;
   logic [SLOT_BITS-1:0]   hold_d;
   logic [2*SLOT_BITS-1:0] shreg_q;
   logic                   sdin_q;
   logic                   tick_q;
   logic                   frameWrap;
   logic                   slotEdge;
   logic                   slotZeroNext;

   assign frameWrap    = &frameCnt_q;
   assign slotEdge     = &frameCnt_q[3:0];
   assign slotZeroNext = &frameCnt_q[8:0];

   // The left channel loads from hold_d so it sees the sample latched on this very
   // edge; the right channel, loaded mid-frame, then carries the identical value.
   assign hold_d = frameWrap ? sample_i : hold_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frameCnt_q <= '0;
         hold_q     <= '0;
         shreg_q    <= '0;
         sdin_q     <= 1'b0;
         tick_q     <= 1'b0;
      end else begin
         frameCnt_q <= frameCnt_q + 1'b1;
         hold_q     <= hold_d;
         tick_q     <= frameWrap;
         if (slotEdge) begin
            if (slotZeroNext) begin
               shreg_q <= {hold_d, {SLOT_BITS{1'b0}}};
               sdin_q  <= 1'b0;
            end else begin
               sdin_q  <= shreg_q[2*SLOT_BITS-1];
               shreg_q <= {shreg_q[2*SLOT_BITS-2:0], 1'b0};
            end
         end
      end
   end

   assign mclk_o       = frameCnt_q[1];
   assign sck_o        = frameCnt_q[3];
   assign lrck_o       = frameCnt_q[9];
   assign sdin_o       = sdin_q;
   assign sampleTick_o = tick_q;

endmodule

// File: rtl/tone_i2s_out.sv
// Square-wave tone generator for Do/Re/Mi feeding the Pmod I2S DAC serializer.
// The wave swings between volume_max and volume_min; silence when no note is held.
module tone_i2s_out
   import audio_pkg::*;
#(
   parameter int TONE_W  = TONE_W_DEF,
   parameter int DO_HALF = DO_HALF_DEF,
   parameter int RE_HALF = RE_HALF_DEF,
   parameter int MI_HALF = MI_HALF_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 Do,
   input  logic                 Re,
   input  logic                 Mi,
   input  logic [SLOT_BITS-1:0] volume_max,
   input  logic [SLOT_BITS-1:0] volume_min,
   output logic                 mclk,
   output logic                 sck,
   output logic                 lrck,
   output logic                 sdin,
   output logic                 sample_tick
);

   note_e                sel;
   note_e                selPrev_q;
   logic [TONE_W-1:0]    half;
   logic [TONE_W-1:0]    toneCnt_q;
   logic [TONE_W-1:0]    toneCnt_d;
   logic                 phase_q;
   logic                 phase_d;
   logic [SLOT_BITS-1:0] toneSample_q;
   logic [SLOT_BITS-1:0] toneSample_d;

   // A new note restarts in the high half so its first toggle lands exactly one
   // half-period later; the sample is built from the next phase for 1-clk latency.
   always_comb begin
      sel       = noteSelect(Do, Re, Mi);
      half      = TONE_W'(MI_HALF);
      toneCnt_d = toneCnt_q + 1'b1;
      phase_d   = phase_q;
      case (sel)
         NOTE_DO: half = TONE_W'(DO_HALF);
         NOTE_RE: half = TONE_W'(RE_HALF);
         default: half = TONE_W'(MI_HALF);
      endcase
      if (sel == NOTE_NONE || sel != selPrev_q) begin
         toneCnt_d = '0;
         phase_d   = 1'b1;
      end else if (toneCnt_q == half - 1'b1) begin
         toneCnt_d = '0;
         phase_d   = ~phase_q;
      end
      if (sel == NOTE_NONE) toneSample_d = '0;
      else                  toneSample_d = phase_d ? volume_max : volume_min;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         selPrev_q    <= NOTE_NONE;
         toneCnt_q    <= '0;
         phase_q      <= 1'b1;
         toneSample_q <= '0;
      end else begin
         selPrev_q    <= sel;
         toneCnt_q    <= toneCnt_d;
         phase_q      <= phase_d;
         toneSample_q <= toneSample_d;
      end
   end

   i2s_serializer u_serializer (
      .clk          (clk),
      .rst_n        (rst_n),
      .sample_i     (toneSample_q),
      .mclk_o       (mclk),
      .sck_o        (sck),
      .lrck_o       (lrck),
      .sdin_o       (sdin),
      .sampleTick_o (sample_tick)
   );

endmodule

// File: tb/tb_tone_i2s_out.sv
// Directed bench for tone_i2s_out: frame clocks, slot contents, tone timing and reset.
// Uses shortened half-periods so several tone toggles fit in a short run.
module tb_tone_i2s_out;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        Do = 1'b0, Re = 1'b0, Mi = 1'b0;
   logic [15:0] volume_max = '0, volume_min = '0;
   logic        mclk, sck, lrck, sdin, sample_tick;

   int compared = 0;
   int mismatched = 0;
   int cyc = 0;

   typedef struct {
      logic        d, r, m;
      logic [15:0] vmax, vmin, expSample;
   } vec_t;

   vec_t vecs [6];

   tone_i2s_out #(
      .TONE_W  (18),
      .DO_HALF (2000),
      .RE_HALF (1500),
      .MI_HALF (1000)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .Do          (Do),
      .Re          (Re),
      .Mi          (Mi),
      .volume_max  (volume_max),
      .volume_min  (volume_min),
      .mclk        (mclk),
      .sck         (sck),
      .lrck        (lrck),
      .sdin        (sdin),
      .sample_tick (sample_tick)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic stepClk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic d, input logic r, input logic m,
                                input logic [15:0] vmax, input logic [15:0] vmin);
      Do = d; Re = r; Mi = m;
      volume_max = vmax; volume_min = vmin;
   endtask

   task automatic waitTick();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 2100; i++) begin
         stepClk(1);
         if (sample_tick) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL tick_timeout: got no sample_tick, expected one within 2100 clk");
      end
   endtask

   // Starts right after a sample_tick edge (frame_cnt = 0), ends after the next one.
   task automatic captureFrame(output logic [63:0] bits);
      for (int s = 0; s < 64; s++) begin
         bits[63-s] = sdin;
         checkOutput("slot_lrck", {31'b0, lrck}, {31'b0, (s >= 32)});
         stepClk(16);
      end
      checkOutput("frame_tick", {31'b0, sample_tick}, 32'd1);
   endtask

   task automatic checkSample(input string name, input logic [15:0] exp);
      checkOutput(name, {16'b0, dut.toneSample_q}, {16'b0, exp});
   endtask

   initial begin
      logic [63:0] bits;
      logic [31:0] expWord;
      logic [15:0] expHold;
      int          e0;
      int          r;
      int          fc;

      vecs[0] = '{d:1'b1, r:1'b0, m:1'b0, vmax:16'h7999, vmin:16'h8667, expSample:16'h7999};
      vecs[1] = '{d:1'b0, r:1'b0, m:1'b0, vmax:16'h7999, vmin:16'h8667, expSample:16'h0000};
      vecs[2] = '{d:1'b0, r:1'b1, m:1'b0, vmax:16'h1234, vmin:16'hFEDC, expSample:16'h1234};
      vecs[3] = '{d:1'b0, r:1'b0, m:1'b1, vmax:16'h8000, vmin:16'h7FFF, expSample:16'h8000};
      vecs[4] = '{d:1'b1, r:1'b0, m:1'b1, vmax:16'hA5A5, vmin:16'h5A5A, expSample:16'hA5A5};
      vecs[5] = '{d:1'b0, r:1'b1, m:1'b1, vmax:16'hFFFF, vmin:16'h0001, expSample:16'hFFFF};

      // Reset state, then the free-running clock ratios from the first edge.
      #23;
      checkOutput("rst_mclk", {31'b0, mclk}, 32'd0);
      checkOutput("rst_sck", {31'b0, sck}, 32'd0);
      checkOutput("rst_lrck", {31'b0, lrck}, 32'd0);
      checkOutput("rst_sdin", {31'b0, sdin}, 32'd0);
      checkOutput("rst_tick", {31'b0, sample_tick}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 1100; k++) begin
         stepClk(1);
         fc = k % 1024;
         checkOutput("clk_mclk", {31'b0, mclk}, {31'b0, fc[1]});
         checkOutput("clk_sck", {31'b0, sck}, {31'b0, fc[3]});
         checkOutput("clk_lrck", {31'b0, lrck}, {31'b0, fc[9]});
         checkOutput("clk_tick", {31'b0, sample_tick}, {31'b0, (k == 1024)});
         checkOutput("clk_sdin", {31'b0, sdin}, 32'd0);
      end

      // Table of note/volume patterns, one captured frame each.
      waitTick();
      for (int v = 0; v < 6; v++) begin
         stepClk(600);
         applyStimulus(1'b0, 1'b0, 1'b0, vecs[v].vmax, vecs[v].vmin);
         stepClk(2);
         applyStimulus(vecs[v].d, vecs[v].r, vecs[v].m, vecs[v].vmax, vecs[v].vmin);
         waitTick();
         captureFrame(bits);
         expWord = {1'b0, vecs[v].expSample, 15'b0};
         checkOutput($sformatf("vec%0d_left", v), bits[63:32], expWord);
         checkOutput($sformatf("vec%0d_right", v), bits[31:0], expWord);
      end

      // Do held: toggles every 2000 clk, and frame holds follow the phase.
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h7999, 16'h8667);
      stepClk(1);
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h7999, 16'h8667);
      stepClk(1);
      e0 = cyc;
      checkSample("do_start", 16'h7999);
      stepClk(1999);
      checkSample("do_pre_toggle", 16'h7999);
      stepClk(1);
      checkSample("do_toggle1", 16'h8667);
      stepClk(1999);
      checkSample("do_pre_toggle2", 16'h8667);
      stepClk(1);
      checkSample("do_toggle2", 16'h7999);
      waitTick();
      for (int f = 0; f < 4; f++) begin
         r = cyc - 1 - e0;
         expHold = (((r / 2000) % 2) == 0) ? 16'h7999 : 16'h8667;
         captureFrame(bits);
         checkOutput($sformatf("hold%0d_left", f), bits[63:32], {1'b0, expHold, 15'b0});
         checkOutput($sformatf("hold%0d_right", f), bits[31:0], {1'b0, expHold, 15'b0});
      end

      // Do and Mi together: Do's period wins, no toggle at Mi's 1000 clk.
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h1111, 16'h2222);
      stepClk(1);
      applyStimulus(1'b1, 1'b0, 1'b1, 16'h1111, 16'h2222);
      stepClk(1);
      checkSample("dm_start", 16'h1111);
      stepClk(1000);
      checkSample("dm_at_1000", 16'h1111);
      stepClk(999);
      checkSample("dm_at_1999", 16'h1111);
      stepClk(1);
      checkSample("dm_at_2000", 16'h2222);

      // Do -> Re 700 clk into the low half restarts high with Re's period.
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h7999, 16'h8667);
      stepClk(1);
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h7999, 16'h8667);
      stepClk(1);
      stepClk(2700);
      checkSample("dr_low_half", 16'h8667);
      applyStimulus(1'b0, 1'b1, 1'b0, 16'h7999, 16'h8667);
      stepClk(1);
      checkSample("dr_switch", 16'h7999);
      stepClk(1499);
      checkSample("dr_pre_toggle", 16'h7999);
      stepClk(1);
      checkSample("dr_toggle", 16'h8667);

      // Mid-frame asynchronous reset at frame_cnt = 300.
      waitTick();
      stepClk(300);
      checkOutput("mid_sck", {31'b0, sck}, 32'd1);
      checkOutput("mid_mclk", {31'b0, mclk}, 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("arst_mclk", {31'b0, mclk}, 32'd0);
      checkOutput("arst_sck", {31'b0, sck}, 32'd0);
      checkOutput("arst_lrck", {31'b0, lrck}, 32'd0);
      checkOutput("arst_sdin", {31'b0, sdin}, 32'd0);
      checkOutput("arst_tick", {31'b0, sample_tick}, 32'd0);
      checkSample("arst_sample", 16'h0000);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      stepClk(8);
      checkOutput("rel_sck", {31'b0, sck}, 32'd1);
      stepClk(503);
      checkOutput("rel_lrck_511", {31'b0, lrck}, 32'd0);
      stepClk(1);
      checkOutput("rel_lrck_512", {31'b0, lrck}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
